// File: rtl/irq_request_unit.sv
// 8-channel interrupt request front end: synchronises and edge-detects raw requests,
// masks them, and runs the request/acknowledge/end-of-interrupt handshake with a one-hot grant.
module irq_request_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       mask_we,
    input  logic [7:0] mask_din,
    input  logic       ack,
    input  logic       eoi,
    output logic       irq,
    output logic [7:0] grant,
    output logic [7:0] pend,
    output logic [7:0] mask
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] s3;
    logic [1:0] warm;
    logic [7:0] rise;
    logic [7:0] act;
    logic [7:0] sel;
    logic [7:0] clr;
    logic [7:0] in_svc;
    logic [7:0] in_svc_next;
    logic       irq_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= 8'h00;
            s2   <= 8'h00;
            s3   <= 8'h00;
            warm <= 2'd0;
        end else begin
            s1 <= req;
            s2 <= s1;
            s3 <= s2;
            if (warm != 2'd3) begin
                warm <= warm + 2'd1;
            end
        end
    end

    // Edges are ignored until s3 holds a real sample, so a line already high
    // when reset releases is treated as a level, not a new request.
    assign rise = (warm == 2'd3) ? (s2 & ~s3) : 8'h00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= 8'h00;
            mask <= 8'h00;
        end else begin
            pend <= (pend & ~clr) | rise;
            if (mask_we) begin
                mask <= mask_din;
            end
        end
    end

    assign act = pend & ~mask;

    always_comb begin
        sel = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (act[i]) begin
                sel    = 8'h00;
                sel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            in_svc <= 8'h00;
            irq_q  <= 1'b0;
        end else begin
            state  <= state_next;
            in_svc <= in_svc_next;
            irq_q  <= (state_next == S_ASSERT);
        end
    end

    // Next-state logic; the pending clear and in-service capture are transition actions.
    always_comb begin
        state_next  = state;
        in_svc_next = in_svc;
        clr         = 8'h00;
        case (state)
            S_IDLE: begin
                if (act != 8'h00) begin
                    state_next = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (ack && (sel != 8'h00)) begin
                    in_svc_next = sel;
                    clr         = sel;
                    state_next  = S_SERVICE;
                end else if (act == 8'h00) begin
                    state_next = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (eoi) begin
                    in_svc_next = 8'h00;
                    state_next  = S_IDLE;
                end
            end
            default: begin
                in_svc_next = 8'h00;
                state_next  = S_IDLE;
            end
        endcase
    end

    always_comb begin
        irq   = irq_q;
        grant = 8'h00;
        case (state)
            S_ASSERT:  grant = sel;
            S_SERVICE: grant = in_svc;
            default:   grant = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_irq_request_unit.sv
// Directed bench for irq_request_unit: expectations are queued as stimulus is applied
// and popped against the DUT outputs at the following falling edge.
module tb_irq_request_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       mask_we;
    logic [7:0] mask_din;
    logic       ack;
    logic       eoi;
    logic       irq;
    logic [7:0] grant;
    logic [7:0] pend;
    logic [7:0] mask;

    typedef struct {
        string      tag;
        logic       irq;
        logic [7:0] grant;
        logic [7:0] pend;
        logic [7:0] mask;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] mask_model = 8'h00;

    irq_request_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .mask_we  (mask_we),
        .mask_din (mask_din),
        .ack      (ack),
        .eoi      (eoi),
        .irq      (irq),
        .grant    (grant),
        .pend     (pend),
        .mask     (mask)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [7:0] r, input logic a, input logic e);
        req = r;
        ack = a;
        eoi = e;
    endtask

    task automatic writeMask(input logic [7:0] v);
        mask_we    = 1'b1;
        mask_din   = v;
        mask_model = v;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expectOut(input string tag, input logic i, input logic [7:0] g,
                             input logic [7:0] p);
        exp_t e;
        e.tag   = tag;
        e.irq   = i;
        e.grant = g;
        e.pend  = p;
        e.mask  = mask_model;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL scoreboard_empty: observed=no entry expected=entry");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (irq === e.irq) else begin
            failures++;
            $error("[TB] FAIL %s.irq: observed=%b expected=%b", e.tag, irq, e.irq);
        end
        checks++;
        assert (grant === e.grant) else begin
            failures++;
            $error("[TB] FAIL %s.grant: observed=%h expected=%h", e.tag, grant, e.grant);
        end
        checks++;
        assert (pend === e.pend) else begin
            failures++;
            $error("[TB] FAIL %s.pend: observed=%h expected=%h", e.tag, pend, e.pend);
        end
        checks++;
        assert (mask === e.mask) else begin
            failures++;
            $error("[TB] FAIL %s.mask: observed=%h expected=%h", e.tag, mask, e.mask);
        end
    endtask

    task automatic stepCheck(input int n, input string tag, input logic i,
                             input logic [7:0] g, input logic [7:0] p);
        expectOut(tag, i, g, p);
        step(n);
        checkOutput();
    endtask

    initial begin
        rst_n    = 1'b0;
        mask_we  = 1'b0;
        mask_din = 8'h00;
        applyStimulus(8'hFF, 1'b0, 1'b0);
        stepCheck(2, "reset", 1'b0, 8'h00, 8'h00);
        rst_n = 1'b1;
        stepCheck(6, "no_edge_after_reset", 1'b0, 8'h00, 8'h00);
        applyStimulus(8'h00, 1'b0, 1'b0);
        step(4);

        $display("[TB] single request on channel 3");
        applyStimulus(8'h08, 1'b0, 1'b0);
        stepCheck(2, "pend_latency_early", 1'b0, 8'h00, 8'h00);
        stepCheck(1, "pend_set", 1'b0, 8'h00, 8'h08);
        stepCheck(1, "irq_assert", 1'b1, 8'h08, 8'h08);
        step(1);
        applyStimulus(8'h08, 1'b1, 1'b0);
        stepCheck(1, "ack_clear", 1'b0, 8'h08, 8'h00);
        applyStimulus(8'h08, 1'b0, 1'b0);
        stepCheck(2, "service_hold", 1'b0, 8'h08, 8'h00);
        applyStimulus(8'h08, 1'b0, 1'b1);
        stepCheck(1, "eoi_release", 1'b0, 8'h00, 8'h00);
        applyStimulus(8'h08, 1'b0, 1'b0);
        stepCheck(2, "held_req_single_event", 1'b0, 8'h00, 8'h00);
        applyStimulus(8'h08, 1'b1, 1'b0);
        stepCheck(1, "ack_in_idle", 1'b0, 8'h00, 8'h00);

        $display("[TB] priority and preemption");
        applyStimulus(8'h0C, 1'b0, 1'b0);
        stepCheck(4, "low_prio_grant", 1'b1, 8'h04, 8'h04);
        applyStimulus(8'h0C, 1'b0, 1'b1);
        stepCheck(1, "eoi_in_assert", 1'b1, 8'h04, 8'h04);
        applyStimulus(8'h4C, 1'b0, 1'b0);
        stepCheck(2, "preempt_pending", 1'b1, 8'h04, 8'h04);
        stepCheck(1, "preempt_grant", 1'b1, 8'h40, 8'h44);
        applyStimulus(8'h4C, 1'b1, 1'b0);
        stepCheck(1, "ack_high", 1'b0, 8'h40, 8'h04);
        applyStimulus(8'h4C, 1'b0, 1'b1);
        stepCheck(1, "eoi_gap", 1'b0, 8'h00, 8'h04);
        applyStimulus(8'h4C, 1'b0, 1'b0);
        stepCheck(1, "reassert_low", 1'b1, 8'h04, 8'h04);
        applyStimulus(8'h4C, 1'b1, 1'b0);
        stepCheck(1, "ack_low", 1'b0, 8'h04, 8'h00);
        applyStimulus(8'h4C, 1'b0, 1'b1);
        stepCheck(1, "eoi_low", 1'b0, 8'h00, 8'h00);
        applyStimulus(8'h00, 1'b0, 1'b0);
        step(3);

        $display("[TB] masking");
        writeMask(8'h80);
        stepCheck(1, "mask_write", 1'b0, 8'h00, 8'h00);
        mask_we = 1'b0;
        applyStimulus(8'h80, 1'b0, 1'b0);
        stepCheck(3, "masked_pend", 1'b0, 8'h00, 8'h80);
        stepCheck(2, "masked_no_irq", 1'b0, 8'h00, 8'h80);
        writeMask(8'h00);
        stepCheck(1, "unmask_edge", 1'b0, 8'h00, 8'h80);
        mask_we = 1'b0;
        stepCheck(1, "unmask_irq", 1'b1, 8'h80, 8'h80);
        writeMask(8'h80);
        stepCheck(1, "mask_in_assert", 1'b1, 8'h00, 8'h80);
        mask_we = 1'b0;
        stepCheck(1, "mask_drop_idle", 1'b0, 8'h00, 8'h80);
        writeMask(8'h00);
        stepCheck(1, "unmask_again_edge", 1'b0, 8'h00, 8'h80);
        mask_we = 1'b0;
        stepCheck(1, "unmask_again", 1'b1, 8'h80, 8'h80);
        applyStimulus(8'h80, 1'b1, 1'b0);
        stepCheck(1, "ack_ch7", 1'b0, 8'h80, 8'h00);
        applyStimulus(8'h80, 1'b0, 1'b1);
        stepCheck(1, "eoi_ch7", 1'b0, 8'h00, 8'h00);
        applyStimulus(8'h00, 1'b0, 1'b0);
        step(3);

        $display("[TB] set beats clear on channel 5");
        applyStimulus(8'h20, 1'b0, 1'b0);
        stepCheck(4, "ch5_assert", 1'b1, 8'h20, 8'h20);
        applyStimulus(8'h00, 1'b0, 1'b0);
        step(3);
        applyStimulus(8'h20, 1'b0, 1'b0);
        step(2);
        applyStimulus(8'h20, 1'b1, 1'b0);
        stepCheck(1, "set_beats_clear", 1'b0, 8'h20, 8'h20);
        applyStimulus(8'h20, 1'b0, 1'b1);
        stepCheck(1, "sbc_eoi", 1'b0, 8'h00, 8'h20);
        applyStimulus(8'h20, 1'b0, 1'b0);
        stepCheck(1, "sbc_reassert", 1'b1, 8'h20, 8'h20);
        applyStimulus(8'h20, 1'b1, 1'b0);
        stepCheck(1, "sbc_ack2", 1'b0, 8'h20, 8'h00);
        applyStimulus(8'h20, 1'b0, 1'b1);
        stepCheck(1, "sbc_eoi2", 1'b0, 8'h00, 8'h00);
        applyStimulus(8'h00, 1'b0, 1'b0);
        step(3);

        $display("[TB] reset during service");
        applyStimulus(8'h10, 1'b0, 1'b0);
        stepCheck(4, "ch4_assert", 1'b1, 8'h10, 8'h10);
        applyStimulus(8'h10, 1'b1, 1'b0);
        stepCheck(1, "ch4_service", 1'b0, 8'h10, 8'h00);
        applyStimulus(8'h12, 1'b0, 1'b0);
        writeMask(8'h01);
        stepCheck(1, "mask_in_service", 1'b0, 8'h10, 8'h00);
        mask_we = 1'b0;
        stepCheck(2, "pend_in_service", 1'b0, 8'h10, 8'h02);
        rst_n      = 1'b0;
        mask_model = 8'h00;
        stepCheck(1, "reset_in_service", 1'b0, 8'h00, 8'h00);
        rst_n = 1'b1;
        stepCheck(5, "post_reset_clean", 1'b0, 8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
